// File: rtl/branch_backup_fifo.sv
// rtl/branch_backup_fifo.sv - backup-PC FIFO for in-flight branch predictions
// Optional sticky overflow/underflow flag: define BRANCH_BACKUP_FIFO_ERR_EN.
module branch_backup_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             select,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic [WIDTH-1:0] P,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sel_data;
  logic             do_push, do_pop;

  assign sel_data = (enable & ~select) ? I2 : I1;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign P        = p_q;

  // A pop frees a slot in the same edge, so push on full is legal alongside it.
  assign do_pop  = ~clear & pop & ~empty;
  assign do_push = ~clear & push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    p_d      = p_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      p_d      = '0;
    end else begin
      if (do_pop) begin
        p_d      = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      p_q      <= p_d;
    end
  end

  // Entry storage carries no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= sel_data;
    end
  end

`ifdef BRANCH_BACKUP_FIFO_ERR_EN
  logic err_q;
  logic overflow, underflow;

  assign overflow  = ~clear & push & full & ~pop;
  assign underflow = ~clear & pop & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (overflow || underflow) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && overflow)  $error("branch_backup_fifo: overflow, push dropped");
    if (rst_n && underflow) $error("branch_backup_fifo: underflow, pop ignored");
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_branch_backup_fifo.sv
// tb/tb_branch_backup_fifo.sv - directed table plus randomized model check of branch_backup_fifo
module tb_branch_backup_fifo;

  localparam int WIDTH = 11;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef BRANCH_BACKUP_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0, enable = 1'b0, select = 1'b0, push = 1'b0, pop = 1'b0;
  logic [WIDTH-1:0] I1 = '0, I2 = '0;
  logic [WIDTH-1:0] P;
  logic [CNT_W-1:0] count;
  logic             full, empty, err;

  branch_backup_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .select(select),
    .push(push), .pop(pop), .I1(I1), .I2(I2), .P(P), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             clr, en, sel, pu, po;
    logic [WIDTH-1:0] i1, i2;
    logic [WIDTH-1:0] exp_p;
    int               exp_cnt;
    bit               exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] ep, input int ecnt, input bit eerr);
    chk({tag, ".P"},     32'(P),     32'(ep));
    chk({tag, ".count"}, 32'(count), 32'(ecnt));
    chk({tag, ".full"},  32'(full),  32'(ecnt == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(ecnt == 0));
    chk({tag, ".err"},   32'(err),   32'(eerr & ERR_EN));
  endtask

  function automatic void add(input logic c, input logic e, input logic s, input logic pu,
                              input logic po, input int i1, input int i2,
                              input int ep, input int ecnt, input bit eerr);
    vec_t v;
    v.clr = c; v.en = e; v.sel = s; v.pu = pu; v.po = po;
    v.i1 = WIDTH'(i1); v.i2 = WIDTH'(i2); v.exp_p = WIDTH'(ep);
    v.exp_cnt = ecnt; v.exp_err = eerr;
    vt.push_back(v);
  endfunction

  task automatic drive(input logic c, input logic e, input logic s, input logic pu,
                       input logic po, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    clear = c; enable = e; select = s; push = pu; pop = po; I1 = a; I2 = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_p;
  bit               m_err;

  initial begin
    // clr en sel push pop  I1  I2   expP  cnt err
    add(0, 0, 1, 1, 0, 'h101, 'h000, 'h000, 1, 0);
    add(0, 1, 0, 1, 0, 'h7FF, 'h055, 'h000, 2, 0);
    add(0, 0, 0, 0, 1, 'h000, 'h000, 'h101, 1, 0);
    add(0, 0, 0, 0, 1, 'h000, 'h000, 'h055, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 1, 0, k, 'h7AA, 'h055, k, 0);
    add(0, 0, 0, 1, 0, 'h005, 'h000, 'h055, 4, 1);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 1, 0, 0, k, 4 - k, 1);
    for (int k = 0; k < 4; k++) add(0, 1, 1, 1, 0, 'h010 + k, 'h6CC, 'h004, k + 1, 1);
    add(0, 1, 1, 1, 1, 'h020, 'h000, 'h010, 4, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h011, 3, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h012, 2, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h013, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h020, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 'h000, 0, 1);
    add(0, 0, 0, 1, 1, 'h3AA, 0, 'h000, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h3AA, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h3AA, 0, 1);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 1, 0, 'h0A0 + k, 0, 'h3AA, k, 1);
    add(1, 0, 0, 1, 0, 'h111, 0, 'h000, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 'h000, 0, 1);

    // Reset released away from the clock edge
    #12;
    chk_all("reset", '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("idle", '0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].clr, vt[i].en, vt[i].sel, vt[i].pu, vt[i].po, vt[i].i1, vt[i].i2);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].exp_p, vt[i].exp_cnt, vt[i].exp_err);
    end

    // Asynchronous reset asserted mid-cycle with state held
    drive(0, 0, 0, 1, 0, 'h02B, 0); step();
    drive(0, 0, 0, 1, 1, 'h04C, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_all("pre_rst", 'h02B, 1, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", '0, 0, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk_all("post_rst", '0, 0, 0);

    // Randomized traffic against a queue model
    mq.delete();
    m_p = '0;
    m_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic c, e, s, pu, po;
      logic [WIDTH-1:0] a, b, d;
      c  = ($urandom_range(0, 31) == 0);
      e  = 1'($urandom);
      s  = 1'($urandom);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      drive(c, e, s, pu, po, a, b);
      d = (e && !s) ? b : a;
      if (c) begin
        mq.delete();
        m_p = '0;
      end else begin
        int sz;
        bit popped;
        sz = mq.size();
        popped = 1'b0;
        if (po && sz == 0) m_err = 1'b1;
        if (pu && sz == DEPTH && !po) m_err = 1'b1;
        if (po && sz > 0) begin
          m_p = mq.pop_front();
          popped = 1'b1;
        end
        if (pu && (sz < DEPTH || popped)) mq.push_back(d);
      end
      step();
      chk_all($sformatf("rnd%0d", n), m_p, mq.size(), m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
